// File: rtl/ibex_pmc_wb_source_if.sv
// ---------------------------------------------------------------------------
// ibex_pmc_wb_source_if
//
// Bundles the counter-read request channel and the register-file PMC write
// port of ibex_pmc_wb_source.
//
//   req_valid / req_ready   request handshake (accept on valid & ready)
//   req_idx                 counter index, $clog2(NumCounters) bits
//   req_clear               read-and-clear
//   req_waddr               destination register
//   rf_we_id / rf_we_lsu    other writeback sources busy this cycle
//   rf_we_pmc               PMC write strobe
//   rf_wdata_pmc            PMC write data
//   rf_waddr_pmc            PMC write address
//
// Modports: master = requester / writeback side, slave = the PMC unit.
// ---------------------------------------------------------------------------
interface ibex_pmc_wb_source_if #(
   parameter int unsigned NumCounters = 8
);
   localparam int unsigned IdxW = $clog2(NumCounters);

   logic            req_valid;
   logic            req_ready;
   logic [IdxW-1:0] req_idx;
   logic            req_clear;
   logic [4:0]      req_waddr;
   logic            rf_we_id;
   logic            rf_we_lsu;
   logic            rf_we_pmc;
   logic [31:0]     rf_wdata_pmc;
   logic [4:0]      rf_waddr_pmc;

   modport master (
      output req_valid, req_idx, req_clear, req_waddr, rf_we_id, rf_we_lsu,
      input  req_ready, rf_we_pmc, rf_wdata_pmc, rf_waddr_pmc
   );

   modport slave (
      input  req_valid, req_idx, req_clear, req_waddr, rf_we_id, rf_we_lsu,
      output req_ready, rf_we_pmc, rf_wdata_pmc, rf_waddr_pmc
   );
endinterface

// File: rtl/ibex_pmc_wb_source.sv
// ---------------------------------------------------------------------------
// ibex_pmc_wb_source
//
// Performance-monitor counter bank plus the producer side of the register-file
// PMC write port. Counter reads (optionally read-and-clear) are snapshotted
// into a small FIFO and written back only in cycles where neither the ID nor
// the LSU write source is active, keeping the writeback enables one-hot.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   cnt_en_i          global count enable
//   event_i           per-counter increment strobe
//   flush_i           discard all queued writes (blocks new requests)
//   bus               request channel + PMC write port (slave modport)
//   pending_mask_o    OR of one-hot destination regs of queued entries, bit 0 = 0
//   overflow_o        sticky per-counter wrap flag
// ---------------------------------------------------------------------------
module ibex_pmc_wb_source #(
   parameter int unsigned NumCounters  = 8,
   parameter int unsigned CounterWidth = 32,
   parameter int unsigned FifoDepth    = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   cnt_en_i,
   input  logic [NumCounters-1:0] event_i,
   input  logic                   flush_i,
   ibex_pmc_wb_source_if.slave    bus,
   output logic [31:0]            pending_mask_o,
   output logic [NumCounters-1:0] overflow_o
);

   localparam int unsigned IdxW = $clog2(NumCounters);
   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned OccW = $clog2(FifoDepth + 1);

   // Wrapping pointer increment; depth need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      if (ptr == PtrW'(FifoDepth - 1)) begin
         return '0;
      end else begin
         return ptr + PtrW'(1'b1);
      end
   endfunction

   logic [CounterWidth-1:0] cnt_r [NumCounters];
   logic [NumCounters-1:0]  ovf_r;
   logic [31:0]             fifo_data_r [FifoDepth];
   logic [4:0]              fifo_addr_r [FifoDepth];
   logic [PtrW-1:0]         rd_ptr_r;
   logic [PtrW-1:0]         wr_ptr_r;
   logic [OccW-1:0]         occ_r;

   logic                    empty_s;
   logic                    full_s;
   logic                    ready_s;
   logic                    accept_s;
   logic                    pop_s;
   logic [NumCounters-1:0]  sel_s;
   logic [NumCounters-1:0]  inc_s;
   logic [NumCounters-1:0]  clr_s;
   logic [31:0]             snap_s;
   logic [31:0]             head_data_s;
   logic [4:0]              head_addr_s;
   logic [31:0]             mask_s;

   assign empty_s  = (occ_r == '0);
   assign full_s   = (occ_r == OccW'(FifoDepth));
   assign ready_s  = ~full_s & ~flush_i;
   assign accept_s = bus.req_valid & ready_s;
   // Only write when no other writeback source owns the port this cycle.
   assign pop_s    = ~empty_s & ~bus.rf_we_id & ~bus.rf_we_lsu & ~flush_i;
   assign inc_s    = {NumCounters{cnt_en_i}} & event_i;
   assign clr_s    = sel_s & {NumCounters{accept_s & bus.req_clear}};

   // Decode the requested index; an out-of-range index selects nothing,
   // which yields a zero snapshot and suppresses the clear.
   always_comb begin
      sel_s  = '0;
      snap_s = 32'h0;
      for (int unsigned i = 0; i < NumCounters; i++) begin
         if (bus.req_idx == IdxW'(i)) begin
            sel_s[i] = 1'b1;
            snap_s   = 32'(cnt_r[i]);
         end else begin
            sel_s[i] = 1'b0;
         end
      end
   end

   // Event counters with sticky wrap flags; a clear beats a same-cycle wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumCounters; i++) begin
            cnt_r[i] <= '0;
         end
         ovf_r <= '0;
      end else begin
         for (int unsigned i = 0; i < NumCounters; i++) begin
            if (clr_s[i]) begin
               cnt_r[i] <= inc_s[i] ? CounterWidth'(1'b1) : '0;
               ovf_r[i] <= 1'b0;
            end else if (inc_s[i]) begin
               cnt_r[i] <= cnt_r[i] + CounterWidth'(1'b1);
               if (&cnt_r[i]) begin
                  ovf_r[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Pending-write FIFO: flush empties it, otherwise push/pop independently.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         occ_r    <= '0;
         for (int unsigned k = 0; k < FifoDepth; k++) begin
            fifo_data_r[k] <= 32'h0;
            fifo_addr_r[k] <= 5'd0;
         end
      end else if (flush_i) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         occ_r    <= '0;
      end else begin
         if (accept_s) begin
            fifo_data_r[wr_ptr_r] <= snap_s;
            fifo_addr_r[wr_ptr_r] <= bus.req_waddr;
            wr_ptr_r              <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({accept_s, pop_s})
            2'b10:   occ_r <= occ_r + OccW'(1'b1);
            2'b01:   occ_r <= occ_r - OccW'(1'b1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Head entry presented on the write port, zero while empty.
   always_comb begin
      if (empty_s) begin
         head_data_s = 32'h0;
         head_addr_s = 5'd0;
      end else begin
         head_data_s = fifo_data_r[rd_ptr_r];
         head_addr_s = fifo_addr_r[rd_ptr_r];
      end
   end

   // A slot is live when its distance from the read pointer is below the
   // occupancy; x0 destinations never show up in the mask.
   always_comb begin
      mask_s = 32'h0;
      for (int unsigned k = 0; k < FifoDepth; k++) begin
         if (((k + FifoDepth - 32'(rd_ptr_r)) % FifoDepth) < 32'(occ_r)) begin
            mask_s = mask_s | (32'h1 << fifo_addr_r[k]);
         end else begin
            mask_s = mask_s;
         end
      end
      mask_s[0] = 1'b0;
   end

   assign bus.req_ready    = ready_s;
   assign bus.rf_we_pmc    = pop_s;
   assign bus.rf_wdata_pmc = head_data_s;
   assign bus.rf_waddr_pmc = head_addr_s;
   assign pending_mask_o   = mask_s;
   assign overflow_o       = ovf_r;

   // The PMC strobe must never coincide with another writeback source.
   wb_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.rf_we_pmc && (bus.rf_we_id || bus.rf_we_lsu)));

endmodule

// File: tb/tb_ibex_pmc_wb_source.sv
module tb_ibex_pmc_wb_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        cnt_en;
   logic [7:0]  ev;
   logic        flush;
   logic [31:0] mask;
   logic [7:0]  ovf;

   logic        cnt_en4;
   logic [5:0]  ev4;
   logic        flush4;
   logic [31:0] mask4;
   logic [5:0]  ovf4;

   ibex_pmc_wb_source_if #(.NumCounters(8)) bus ();
   ibex_pmc_wb_source_if #(.NumCounters(6)) bus4 ();

   ibex_pmc_wb_source #(.NumCounters(8), .CounterWidth(32), .FifoDepth(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(cnt_en), .event_i(ev), .flush_i(flush),
      .bus(bus), .pending_mask_o(mask), .overflow_o(ovf));

   ibex_pmc_wb_source #(.NumCounters(6), .CounterWidth(4), .FifoDepth(1)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(cnt_en4), .event_i(ev4), .flush_i(flush4),
      .bus(bus4), .pending_mask_o(mask4), .overflow_o(ovf4));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model of the 8-counter instance ----------------
   typedef struct { logic [31:0] d; logic [4:0] a; } ent_t;
   longint unsigned m_cnt [8];
   bit [7:0]        m_ovf;
   ent_t            m_q [$];

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_ovf = 8'h00;
      m_q.delete();
   endtask

   typedef struct {
      logic en; logic [7:0] ev; logic v; logic [2:0] idx; logic clr; logic [4:0] wa;
      logic fl; logic id; logic lsu;
      logic e_rdy; logic e_we; logic [31:0] e_wd; logic [4:0] e_wa; logic [31:0] e_mask;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(logic en, logic [7:0] e, logic v, logic [2:0] idx, logic clr,
                               logic [4:0] wa, logic fl, logic id, logic lsu, logic rdy,
                               logic we, logic [31:0] wd, logic [4:0] ewa, logic [31:0] m);
      vec_t r;
      r.en = en; r.ev = e; r.v = v; r.idx = idx; r.clr = clr; r.wa = wa; r.fl = fl;
      r.id = id; r.lsu = lsu; r.e_rdy = rdy; r.e_we = we; r.e_wd = wd; r.e_wa = ewa;
      r.e_mask = m;
      return r;
   endfunction

   task automatic drive(input vec_t r);
      cnt_en = r.en; ev = r.ev; flush = r.fl;
      bus.req_valid = r.v; bus.req_idx = r.idx; bus.req_clear = r.clr;
      bus.req_waddr = r.wa; bus.rf_we_id = r.id; bus.rf_we_lsu = r.lsu;
   endtask

   // Compare at the negedge, advance the model, then move past the posedge.
   task automatic step(input bit use_tbl, input vec_t r);
      logic        e_rdy, e_we, acc, inc;
      logic [31:0] e_wd, e_mask, snap;
      logic [4:0]  e_wa;
      @(negedge clk);
      e_rdy  = (m_q.size() < 2) && !flush;
      e_we   = (m_q.size() > 0) && !bus.rf_we_id && !bus.rf_we_lsu && !flush;
      e_wd   = (m_q.size() > 0) ? m_q[0].d : 32'h0;
      e_wa   = (m_q.size() > 0) ? m_q[0].a : 5'd0;
      e_mask = 32'h0;
      foreach (m_q[k]) e_mask |= (32'h1 << m_q[k].a);
      e_mask[0] = 1'b0;
      chk("model_ready", {31'h0, bus.req_ready}, {31'h0, e_rdy});
      chk("model_we", {31'h0, bus.rf_we_pmc}, {31'h0, e_we});
      chk("model_wdata", bus.rf_wdata_pmc, e_wd);
      chk("model_waddr", {27'h0, bus.rf_waddr_pmc}, {27'h0, e_wa});
      chk("model_mask", mask, e_mask);
      chk("model_ovf", {24'h0, ovf}, {24'h0, m_ovf});
      if (use_tbl) begin
         chk("tbl_ready", {31'h0, bus.req_ready}, {31'h0, r.e_rdy});
         chk("tbl_we", {31'h0, bus.rf_we_pmc}, {31'h0, r.e_we});
         chk("tbl_wdata", bus.rf_wdata_pmc, r.e_wd);
         chk("tbl_waddr", {27'h0, bus.rf_waddr_pmc}, {27'h0, r.e_wa});
         chk("tbl_mask", mask, r.e_mask);
      end
      acc  = bus.req_valid && e_rdy;
      snap = 32'(m_cnt[bus.req_idx]);
      for (int i = 0; i < 8; i++) begin
         inc = cnt_en && ev[i];
         if (acc && bus.req_clear && (int'(bus.req_idx) == i)) begin
            m_cnt[i] = inc ? 1 : 0;
            m_ovf[i] = 1'b0;
         end else if (inc) begin
            if (m_cnt[i] == 64'hFFFF_FFFF) begin
               m_cnt[i] = 0;
               m_ovf[i] = 1'b1;
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
      if (flush) begin
         m_q.delete();
      end else begin
         if (e_we) void'(m_q.pop_front());
         if (acc) m_q.push_back('{d: snap, a: bus.req_waddr});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc4();
      @(posedge clk);
      #1;
   endtask

   vec_t idle_v;
   vec_t rv;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      idle_v = mk(0, 8'h00, 0, 3'd0, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0, 5'd0, 32'h0);
      rst_n = 1'b0;
      drive(idle_v);
      cnt_en4 = 1'b0; ev4 = 6'h00; flush4 = 1'b0;
      bus4.req_valid = 1'b0; bus4.req_idx = 3'd0; bus4.req_clear = 1'b0;
      bus4.req_waddr = 5'd0; bus4.rf_we_id = 1'b0; bus4.rf_we_lsu = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", {31'h0, bus.rf_we_pmc}, 32'h0);
      chk("rst_wdata", bus.rf_wdata_pmc, 32'h0);
      chk("rst_waddr", {27'h0, bus.rf_waddr_pmc}, 32'h0);
      chk("rst_mask", mask, 32'h0);
      chk("rst_ovf", {24'h0, ovf}, 32'h0);
      rst_n = 1'b1;

      // count 10 events on counter 3, read it into x5
      for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 8'h08, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 3'd3, 0, 5'd5, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd10, 5'd5, 32'h20));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      // counter 2 to 7, read-and-clear while it increments, then read again
      for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 8'h04, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h04, 1, 3'd2, 1, 5'd9, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd7, 5'd9, 32'h200));
      tbl.push_back(mk(0, 8'h00, 1, 3'd2, 0, 5'd10, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd1, 5'd10, 32'h400));
      // fill the FIFO behind a busy LSU for 5 cycles, then drain in order
      tbl.push_back(mk(0, 8'h00, 1, 3'd2, 0, 5'd6, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 3'd3, 0, 5'd7, 0, 0, 1, 1, 0, 32'd1, 5'd6, 32'h40));
      tbl.push_back(mk(0, 8'h00, 1, 3'd1, 0, 5'd8, 0, 0, 1, 0, 0, 32'd1, 5'd6, 32'hC0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd1, 5'd6, 32'hC0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd1, 5'd6, 32'hC0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd1, 5'd6, 32'hC0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd10, 5'd7, 32'h80));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      // two queued entries, then flush together with a request
      tbl.push_back(mk(0, 8'h00, 1, 3'd3, 0, 5'd11, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 3'd3, 0, 5'd12, 0, 0, 1, 1, 0, 32'd10, 5'd11, 32'h800));
      tbl.push_back(mk(0, 8'h00, 1, 3'd3, 0, 5'd13, 1, 0, 0, 0, 0, 32'd10, 5'd11, 32'h1800));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      // x0 destination is written but never appears in the mask
      tbl.push_back(mk(0, 8'h00, 1, 3'd3, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd10, 5'd0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      // busy ID path stalls the head
      tbl.push_back(mk(0, 8'h00, 1, 3'd2, 0, 5'd14, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd1, 5'd14, 32'h4000));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd1, 5'd14, 32'h4000));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i]);
         step(1'b1, tbl[i]);
      end
      drive(idle_v);

      // 4-bit counters, 6 counters, single-entry FIFO
      cnt_en4 = 1'b1; ev4 = 6'h01;
      repeat (15) cyc4();
      chk("u4_ovf_before_wrap", {26'h0, ovf4}, 32'h0);
      cyc4();
      chk("u4_ovf_after_wrap", {26'h0, ovf4}, 32'h1);
      ev4 = 6'h00;
      bus4.req_valid = 1'b1; bus4.req_idx = 3'd0; bus4.req_clear = 1'b0; bus4.req_waddr = 5'd3;
      cyc4();
      bus4.req_valid = 1'b0;
      #3;
      chk("u4_wrapped_value", bus4.rf_wdata_pmc, 32'h0);
      chk("u4_we", {31'h0, bus4.rf_we_pmc}, 32'h1);
      chk("u4_full_ready", {31'h0, bus4.req_ready}, 32'h0);
      chk("u4_mask", mask4, 32'h8);
      cyc4();
      ev4 = 6'h01;
      repeat (15) cyc4();
      bus4.req_valid = 1'b1; bus4.req_clear = 1'b1; bus4.req_waddr = 5'd4;
      cyc4();
      bus4.req_valid = 1'b0; bus4.req_clear = 1'b0; ev4 = 6'h00;
      #3;
      chk("u4_clear_snapshot", bus4.rf_wdata_pmc, 32'd15);
      chk("u4_clear_beats_wrap", {26'h0, ovf4}, 32'h0);
      cyc4();
      bus4.req_valid = 1'b1; bus4.req_waddr = 5'd5;
      cyc4();
      bus4.req_valid = 1'b0;
      #3;
      chk("u4_after_clear", bus4.rf_wdata_pmc, 32'd1);
      cyc4();
      bus4.req_valid = 1'b1; bus4.req_idx = 3'd7; bus4.req_clear = 1'b1; bus4.req_waddr = 5'd6;
      cyc4();
      bus4.req_valid = 1'b0; bus4.req_clear = 1'b0;
      #3;
      chk("u4_bad_idx_we", {31'h0, bus4.rf_we_pmc}, 32'h1);
      chk("u4_bad_idx_data", bus4.rf_wdata_pmc, 32'h0);
      cyc4();
      bus4.req_valid = 1'b1; bus4.req_idx = 3'd0; bus4.req_waddr = 5'd7;
      cyc4();
      bus4.req_valid = 1'b0;
      #3;
      chk("u4_bad_idx_no_clear", bus4.rf_wdata_pmc, 32'd1);
      cyc4();
      cnt_en4 = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rv = idle_v;
         rv.en  = 1'($urandom_range(0, 3) != 0);
         rv.ev  = 8'($urandom);
         rv.v   = 1'($urandom_range(0, 1));
         rv.idx = 3'($urandom);
         rv.clr = 1'($urandom_range(0, 3) == 0);
         rv.wa  = 5'($urandom);
         rv.fl  = 1'($urandom_range(0, 9) == 0);
         rv.id  = 1'($urandom_range(0, 3) == 0);
         rv.lsu = 1'($urandom_range(0, 3) == 0);
         drive(rv);
         step(1'b0, rv);
      end

      // async reset with two queued entries
      rv = idle_v;
      rv.lsu = 1'b1; rv.v = 1'b1; rv.idx = 3'd3; rv.wa = 5'd20;
      drive(rv);
      step(1'b0, rv);
      rv.idx = 3'd2; rv.wa = 5'd21;
      drive(rv);
      step(1'b0, rv);
      drive(idle_v);
      #1;
      chk("pre_reset_we", {31'h0, bus.rf_we_pmc}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_we", {31'h0, bus.rf_we_pmc}, 32'h0);
      chk("async_rst_wdata", bus.rf_wdata_pmc, 32'h0);
      chk("async_rst_waddr", {27'h0, bus.rf_waddr_pmc}, 32'h0);
      chk("async_rst_mask", mask, 32'h0);
      chk("async_rst_ovf", {24'h0, ovf}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      rv = idle_v;
      rv.v = 1'b1; rv.idx = 3'd3; rv.wa = 5'd22;
      drive(rv);
      step(1'b0, rv);
      drive(idle_v);
      #1;
      chk("post_rst_counter", bus.rf_wdata_pmc, 32'h0);
      chk("post_rst_waddr", {27'h0, bus.rf_waddr_pmc}, 32'd22);
      step(1'b0, idle_v);
      step(1'b0, idle_v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
